// File: rtl/axi_addr_router_if.sv
// -----------------------------------------------------------------------------
// axi_addr_router_if
//   Bundles the address-channel signals around axi_addr_router.
//
//   Parameters
//     ADDR_W   address width
//     NUM_SLV  number of decoded regions (width of m_sel)
//
//   Signals
//     a_valid / a_ready / a_addr            upstream address handshake
//     m_valid / m_ready / m_addr / m_sel    registered output to the interconnect
//     m_decerr                              held address hit no region
//     rsp_done                              one pulse per completed transaction
//     outs_cnt                              outstanding transaction count
//
//   Modports
//     slave   router side: consumes the upstream channel, drives the output
//     master  environment side: drives the upstream channel, consumes output
// -----------------------------------------------------------------------------
interface axi_addr_router_if #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 6
);
    logic               a_valid;
    logic               a_ready;
    logic [ADDR_W-1:0]  a_addr;
    logic               m_valid;
    logic               m_ready;
    logic [ADDR_W-1:0]  m_addr;
    logic [NUM_SLV-1:0] m_sel;
    logic               m_decerr;
    logic               rsp_done;
    logic [3:0]         outs_cnt;

    modport slave (
        input  a_valid, a_addr, m_ready, rsp_done,
        output a_ready, m_valid, m_addr, m_sel, m_decerr, outs_cnt
    );

    modport master (
        output a_valid, a_addr, m_ready, rsp_done,
        input  a_ready, m_valid, m_addr, m_sel, m_decerr, outs_cnt
    );
endinterface

// File: rtl/axi_addr_router.sv
// -----------------------------------------------------------------------------
// axi_addr_router
//   Registered AXI address-channel decoder (one instance per AW or AR channel).
//   The upstream address is decoded against a parameter region table; the
//   address, a one-hot slave select and a decode-error flag are presented on a
//   single-entry valid/ready output stage. Outstanding transactions are
//   counted and new addresses stall while the count is at MAX_OUTS.
//
//   Optional feature (macro AXI_ROUTER_ORDER_LOCK_EN):
//     When defined, a new address whose decoded target differs from the target
//     of the transactions still outstanding is stalled until all of their
//     responses have returned. This keeps responses from different slaves
//     from completing out of order. When undefined, no target register exists
//     and only the MAX_OUTS limit stalls.
//
//   Parameters
//     ADDR_W    address width
//     NUM_SLV   number of regions / width of m_sel
//     SLV_BASE  region bases, slot i at [i*ADDR_W +: ADDR_W]
//     SLV_MASK  region compare masks, packed like SLV_BASE
//     MAX_OUTS  outstanding transaction limit, 1..15
//
//   Ports
//     clk       clock
//     rst       synchronous active-high reset
//     bus       axi_addr_router_if.slave (upstream channel, output stage,
//               rsp_done pulse, outs_cnt)
// -----------------------------------------------------------------------------
module axi_addr_router #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 6,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {
        32'h8000_0000,   // 5 reserved high
        32'h4000_0000,   // 4 reserved
        32'h7000_0000,   // 3 APB
        32'h4000_0000,   // 2 MTIMER
        32'h4000_0000,   // 1 KPLIC
        32'h0000_0000    // 0 FLASH
    },
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {
        32'h8000_0000,
        32'hC000_0000,
        32'hF000_0000,
        32'hF000_0000,
        32'hFC00_0000,
        32'hC000_0000
    },
    parameter int MAX_OUTS = 4
) (
    input  logic                clk,
    input  logic                rst,
    axi_addr_router_if.slave    bus
);

    localparam logic [3:0] MAX_OUTS_C = 4'(MAX_OUTS);

    // ------------------------------------------------------------------
    // Region decode
    // ------------------------------------------------------------------
    logic [NUM_SLV-1:0] hit_vec;
    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_err;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            hit_vec[i] = ((bus.a_addr & SLV_MASK[i*ADDR_W +: ADDR_W])
                          == SLV_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    // Lowest hitting slot wins so overlapping regions resolve by priority.
    always_comb begin
        dec_sel = '0;
        dec_err = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (hit_vec[i] && dec_err) begin
                dec_sel[i] = 1'b1;
                dec_err    = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               m_valid_q,  m_valid_d;
    logic [ADDR_W-1:0]  m_addr_q,   m_addr_d;
    logic [NUM_SLV-1:0] m_sel_q,    m_sel_d;
    logic               m_decerr_q, m_decerr_d;
    logic [3:0]         outs_cnt_q, outs_cnt_d;

    logic stall;
    logic lock;
    logic a_ready;
    logic accept;
    logic rsp_dec;

    // ------------------------------------------------------------------
    // Ordering lock
    // ------------------------------------------------------------------
`ifdef AXI_ROUTER_ORDER_LOCK_EN
    // Target of the outstanding transactions. A decode error is held as an
    // all-zero select, so comparing the select alone also covers decerr.
    logic [NUM_SLV-1:0] tgt_q, tgt_d;

    always_comb begin
        tgt_d = tgt_q;
        if (accept) begin
            tgt_d = dec_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q <= '0;
        end else begin
            tgt_q <= tgt_d;
        end
    end

    assign lock = (outs_cnt_q != 4'd0) && (dec_sel != tgt_q);
`else
    assign lock = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Stall uses the registered count only, so a same-cycle rsp_done never
    // opens the input early; a_ready stays independent of a_valid.
    assign stall   = (outs_cnt_q == MAX_OUTS_C) || lock;
    assign a_ready = !stall && (!m_valid_q || bus.m_ready);
    assign accept  = bus.a_valid && a_ready;
    assign rsp_dec = bus.rsp_done && (outs_cnt_q != 4'd0);

    // ------------------------------------------------------------------
    // Output stage and outstanding counter
    // ------------------------------------------------------------------
    always_comb begin
        m_valid_d  = m_valid_q;
        m_addr_d   = m_addr_q;
        m_sel_d    = m_sel_q;
        m_decerr_d = m_decerr_q;
        outs_cnt_d = outs_cnt_q;

        if (accept) begin
            m_valid_d  = 1'b1;
            m_addr_d   = bus.a_addr;
            m_sel_d    = dec_sel;
            m_decerr_d = dec_err;
        end else if (m_valid_q && bus.m_ready) begin
            m_valid_d  = 1'b0;
        end

        // Decerr transactions count too: the default slave responds to them.
        if (accept && !rsp_dec) begin
            outs_cnt_d = outs_cnt_q + 4'd1;
        end else if (!accept && rsp_dec) begin
            outs_cnt_d = outs_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_sel_q    <= '0;
            m_decerr_q <= 1'b0;
            outs_cnt_q <= 4'd0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_sel_q    <= m_sel_d;
            m_decerr_q <= m_decerr_d;
            outs_cnt_q <= outs_cnt_d;
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_sel    = m_sel_q;
    assign bus.m_decerr = m_decerr_q;
    assign bus.outs_cnt = outs_cnt_q;

endmodule

// File: tb/tb_axi_addr_router.sv
module tb_axi_addr_router;

    logic clk;
    logic rst;

    int vec_cnt;
    int err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default map, MAX_OUTS=4
    axi_addr_router_if #(.ADDR_W(32), .NUM_SLV(6)) d ();
    axi_addr_router u_dflt (.clk(clk), .rst(rst), .bus(d));

    // Two-region custom map
    axi_addr_router_if #(.ADDR_W(32), .NUM_SLV(2)) t ();
    axi_addr_router #(
        .ADDR_W(32), .NUM_SLV(2),
        .SLV_BASE({32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK({32'h0000_F000, 32'h0000_F000}),
        .MAX_OUTS(4)
    ) u_two (.clk(clk), .rst(rst), .bus(t));

    // Default map, MAX_OUTS=1
    axi_addr_router_if #(.ADDR_W(32), .NUM_SLV(6)) o ();
    axi_addr_router #(.MAX_OUTS(1)) u_one (.clk(clk), .rst(rst), .bus(o));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d.a_valid = 0; d.a_addr = '0; d.m_ready = 1; d.rsp_done = 0;
        t.a_valid = 0; t.a_addr = '0; t.m_ready = 1; t.rsp_done = 0;
        o.a_valid = 0; o.a_addr = '0; o.m_ready = 1; o.rsp_done = 0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        vec_cnt++; if (d.m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid got %b exp 0", d.m_valid); end
        vec_cnt++; if (d.m_addr !== 32'h0) begin err_cnt++; $display("FAIL reset_m_addr got %h exp 0", d.m_addr); end
        vec_cnt++; if (d.m_sel !== 6'b0) begin err_cnt++; $display("FAIL reset_m_sel got %b exp 0", d.m_sel); end
        vec_cnt++; if (d.m_decerr !== 1'b0) begin err_cnt++; $display("FAIL reset_m_decerr got %b exp 0", d.m_decerr); end
        vec_cnt++; if (d.outs_cnt !== 4'd0) begin err_cnt++; $display("FAIL reset_outs_cnt got %0d exp 0", d.outs_cnt); end
        vec_cnt++; if (d.a_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_a_ready got %b exp 1", d.a_ready); end
    endtask

    task automatic test_decode_sweep();
        logic [31:0] sw_addr [6];
        logic [5:0]  sw_sel  [6];
        sw_addr[0] = 32'h1234_0000; sw_sel[0] = 6'b000001;
        sw_addr[1] = 32'h4100_0000; sw_sel[1] = 6'b000010;
        sw_addr[2] = 32'h4800_0000; sw_sel[2] = 6'b000100;
        sw_addr[3] = 32'h7000_0010; sw_sel[3] = 6'b001000;
        sw_addr[4] = 32'h6000_0000; sw_sel[4] = 6'b010000;
        sw_addr[5] = 32'hF000_0000; sw_sel[5] = 6'b100000;
        d.m_ready = 1;
        for (int i = 0; i < 6; i++) begin
            d.a_valid = 1; d.a_addr = sw_addr[i]; d.rsp_done = 0;
            #1;
            vec_cnt++; if (d.a_ready !== 1'b1) begin err_cnt++; $display("FAIL sweep_a_ready[%0d] got %b exp 1", i, d.a_ready); end
            step();
            vec_cnt++; if (d.m_valid !== 1'b1) begin err_cnt++; $display("FAIL sweep_m_valid[%0d] got %b exp 1", i, d.m_valid); end
            vec_cnt++; if (d.m_sel !== sw_sel[i]) begin err_cnt++; $display("FAIL sweep_m_sel[%0d] got %b exp %b", i, d.m_sel, sw_sel[i]); end
            vec_cnt++; if (d.m_addr !== sw_addr[i]) begin err_cnt++; $display("FAIL sweep_m_addr[%0d] got %h exp %h", i, d.m_addr, sw_addr[i]); end
            vec_cnt++; if (d.m_decerr !== 1'b0) begin err_cnt++; $display("FAIL sweep_m_decerr[%0d] got %b exp 0", i, d.m_decerr); end
            vec_cnt++; if (d.outs_cnt !== 4'd1) begin err_cnt++; $display("FAIL sweep_outs_cnt[%0d] got %0d exp 1", i, d.outs_cnt); end
            d.a_valid = 0; d.rsp_done = 1;
            step();
            d.rsp_done = 0;
            vec_cnt++; if (d.m_valid !== 1'b0) begin err_cnt++; $display("FAIL sweep_m_valid_clr[%0d] got %b exp 0", i, d.m_valid); end
        end
    endtask

    task automatic test_back_to_back();
        d.m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            d.a_valid = 1; d.a_addr = 32'h0000_1000 + 32'(i);
            step();
            vec_cnt++; if (d.m_addr !== 32'h0000_1000 + 32'(i)) begin err_cnt++; $display("FAIL b2b_m_addr[%0d] got %h exp %h", i, d.m_addr, 32'h0000_1000 + 32'(i)); end
            vec_cnt++; if (d.outs_cnt !== 4'(i + 1)) begin err_cnt++; $display("FAIL b2b_outs_cnt[%0d] got %0d exp %0d", i, d.outs_cnt, i + 1); end
        end
        d.a_valid = 0; d.rsp_done = 1;
        repeat (3) step();
        d.rsp_done = 0;
        vec_cnt++; if (d.outs_cnt !== 4'd0) begin err_cnt++; $display("FAIL b2b_drain got %0d exp 0", d.outs_cnt); end
    endtask

    task automatic test_backpressure();
        d.m_ready = 0; d.a_valid = 1; d.a_addr = 32'h7000_0000;
        step();
        d.a_addr = 32'h7000_0020;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if (d.a_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_a_ready[%0d] got %b exp 0", i, d.a_ready); end
            vec_cnt++; if (d.m_addr !== 32'h7000_0000) begin err_cnt++; $display("FAIL bp_m_addr[%0d] got %h exp 70000000", i, d.m_addr); end
            step();
        end
        d.m_ready = 1;
        #1;
        vec_cnt++; if (d.a_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_a_ready got %b exp 1", d.a_ready); end
        step();
        vec_cnt++; if (d.m_addr !== 32'h7000_0020) begin err_cnt++; $display("FAIL bp_next_addr got %h exp 70000020", d.m_addr); end
        vec_cnt++; if (d.outs_cnt !== 4'd2) begin err_cnt++; $display("FAIL bp_outs_cnt got %0d exp 2", d.outs_cnt); end
        d.a_valid = 0; d.rsp_done = 1;
        repeat (2) step();
        d.rsp_done = 0;
    endtask

    task automatic test_max_outs();
        d.m_ready = 1; d.a_valid = 1;
        for (int i = 0; i < 4; i++) begin
            d.a_addr = 32'h0000_0100 * 32'(i + 1);
            step();
        end
        d.a_addr = 32'h0000_0500;
        #1;
        vec_cnt++; if (d.outs_cnt !== 4'd4) begin err_cnt++; $display("FAIL max_full_cnt got %0d exp 4", d.outs_cnt); end
        vec_cnt++; if (d.a_ready !== 1'b0) begin err_cnt++; $display("FAIL max_full_a_ready got %b exp 0", d.a_ready); end
        step();
        d.rsp_done = 1;
        step();
        d.rsp_done = 0;
        #1;
        vec_cnt++; if (d.outs_cnt !== 4'd3) begin err_cnt++; $display("FAIL max_after_rsp_cnt got %0d exp 3", d.outs_cnt); end
        vec_cnt++; if (d.a_ready !== 1'b1) begin err_cnt++; $display("FAIL max_after_rsp_a_ready got %b exp 1", d.a_ready); end
        step();
        vec_cnt++; if (d.m_addr !== 32'h0000_0500) begin err_cnt++; $display("FAIL max_fifth_addr got %h exp 00000500", d.m_addr); end
        vec_cnt++; if (d.outs_cnt !== 4'd4) begin err_cnt++; $display("FAIL max_fifth_cnt got %0d exp 4", d.outs_cnt); end
        d.a_valid = 0; d.rsp_done = 1;
        step();
        d.a_valid = 1; d.a_addr = 32'h0000_0600; d.rsp_done = 1;
        step();
        vec_cnt++; if (d.outs_cnt !== 4'd3) begin err_cnt++; $display("FAIL max_simul_cnt got %0d exp 3", d.outs_cnt); end
        vec_cnt++; if (d.m_addr !== 32'h0000_0600) begin err_cnt++; $display("FAIL max_simul_addr got %h exp 00000600", d.m_addr); end
        d.a_valid = 0; d.rsp_done = 1;
        repeat (4) step();
        d.rsp_done = 0;
        vec_cnt++; if (d.outs_cnt !== 4'd0) begin err_cnt++; $display("FAIL max_underflow got %0d exp 0", d.outs_cnt); end
    endtask

    task automatic test_max_one();
        o.m_ready = 1; o.a_valid = 1; o.a_addr = 32'h0000_0100;
        step();
        vec_cnt++; if (o.outs_cnt !== 4'd1) begin err_cnt++; $display("FAIL one_cnt got %0d exp 1", o.outs_cnt); end
        vec_cnt++; if (o.a_ready !== 1'b0) begin err_cnt++; $display("FAIL one_stall got %b exp 0", o.a_ready); end
        step();
        o.rsp_done = 1;
        #1;
        vec_cnt++; if (o.a_ready !== 1'b0) begin err_cnt++; $display("FAIL one_no_bypass got %b exp 0", o.a_ready); end
        step();
        o.rsp_done = 0;
        #1;
        vec_cnt++; if (o.a_ready !== 1'b1) begin err_cnt++; $display("FAIL one_reopen got %b exp 1", o.a_ready); end
        step();
        vec_cnt++; if (o.outs_cnt !== 4'd1) begin err_cnt++; $display("FAIL one_second_cnt got %0d exp 1", o.outs_cnt); end
        o.a_valid = 0; o.rsp_done = 1;
        step();
        o.rsp_done = 0;
    endtask

    task automatic test_decerr();
        t.m_ready = 1; t.a_valid = 1; t.a_addr = 32'h0000_1004;
        step();
        vec_cnt++; if (t.m_sel !== 2'b10) begin err_cnt++; $display("FAIL two_hit_sel got %b exp 10", t.m_sel); end
        vec_cnt++; if (t.m_decerr !== 1'b0) begin err_cnt++; $display("FAIL two_hit_decerr got %b exp 0", t.m_decerr); end
        t.a_valid = 0; t.rsp_done = 1;
        step();
        t.rsp_done = 0; t.a_valid = 1; t.a_addr = 32'h0000_2000;
        step();
        t.a_valid = 0;
        vec_cnt++; if (t.m_sel !== 2'b00) begin err_cnt++; $display("FAIL two_miss_sel got %b exp 00", t.m_sel); end
        vec_cnt++; if (t.m_decerr !== 1'b1) begin err_cnt++; $display("FAIL two_miss_decerr got %b exp 1", t.m_decerr); end
        vec_cnt++; if (t.outs_cnt !== 4'd1) begin err_cnt++; $display("FAIL two_miss_cnt got %0d exp 1", t.outs_cnt); end
        t.rsp_done = 1;
        step();
        t.rsp_done = 0;
    endtask

    task automatic test_order_lock();
        d.m_ready = 1; d.a_valid = 1; d.a_addr = 32'h7000_0000;
        step();
        d.a_addr = 32'h0000_0100;
        #1;
`ifdef AXI_ROUTER_ORDER_LOCK_EN
        for (int i = 0; i < 2; i++) begin
            vec_cnt++; if (d.a_ready !== 1'b0) begin err_cnt++; $display("FAIL lock_stall[%0d] got %b exp 0", i, d.a_ready); end
            step();
        end
        d.rsp_done = 1;
        #1;
        vec_cnt++; if (d.a_ready !== 1'b0) begin err_cnt++; $display("FAIL lock_rsp_cycle got %b exp 0", d.a_ready); end
        step();
        d.rsp_done = 0;
        #1;
        vec_cnt++; if (d.a_ready !== 1'b1) begin err_cnt++; $display("FAIL lock_release got %b exp 1", d.a_ready); end
        step();
        vec_cnt++; if (d.m_addr !== 32'h0000_0100) begin err_cnt++; $display("FAIL lock_accept_addr got %h exp 00000100", d.m_addr); end
        vec_cnt++; if (d.outs_cnt !== 4'd1) begin err_cnt++; $display("FAIL lock_accept_cnt got %0d exp 1", d.outs_cnt); end
        d.a_valid = 0; d.rsp_done = 1;
        step();
`else
        vec_cnt++; if (d.a_ready !== 1'b1) begin err_cnt++; $display("FAIL nolock_ready got %b exp 1", d.a_ready); end
        step();
        vec_cnt++; if (d.m_addr !== 32'h0000_0100) begin err_cnt++; $display("FAIL nolock_addr got %h exp 00000100", d.m_addr); end
        vec_cnt++; if (d.outs_cnt !== 4'd2) begin err_cnt++; $display("FAIL nolock_cnt got %0d exp 2", d.outs_cnt); end
        d.a_valid = 0; d.rsp_done = 1;
        repeat (2) step();
`endif
        d.rsp_done = 0;
        vec_cnt++; if (d.outs_cnt !== 4'd0) begin err_cnt++; $display("FAIL lock_drain got %0d exp 0", d.outs_cnt); end
    endtask

    task automatic test_reset_mid();
        d.m_ready = 1; d.a_valid = 1; d.a_addr = 32'h0000_0100;
        step();
        d.a_addr = 32'h0000_0200;
        step();
        d.a_valid = 0; d.m_ready = 0;
        #1;
        vec_cnt++; if (d.m_valid !== 1'b1 || d.outs_cnt !== 4'd2) begin err_cnt++; $display("FAIL rstmid_pre got valid %b cnt %0d exp 1/2", d.m_valid, d.outs_cnt); end
        rst = 1;
        step();
        rst = 0;
        vec_cnt++; if (d.m_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_m_valid got %b exp 0", d.m_valid); end
        vec_cnt++; if (d.outs_cnt !== 4'd0) begin err_cnt++; $display("FAIL rstmid_cnt got %0d exp 0", d.outs_cnt); end
        vec_cnt++; if (d.m_sel !== 6'b0) begin err_cnt++; $display("FAIL rstmid_m_sel got %b exp 0", d.m_sel); end
        d.m_ready = 1; d.rsp_done = 1;
        step();
        d.rsp_done = 0;
        vec_cnt++; if (d.outs_cnt !== 4'd0) begin err_cnt++; $display("FAIL rstmid_rsp_after got %0d exp 0", d.outs_cnt); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_decode_sweep();
        test_back_to_back();
        test_backpressure();
        test_max_outs();
        test_max_one();
        test_decerr();
        test_order_lock();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
